// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one 128-bit BRAM port between the data-side and
// instruction-side encryption units. Data has priority. A starvation counter
// forces an instruction grant after STARVE_LIMIT back-to-back data grants.
// Latency: req in IDLE cycle T -> mem_req in T+1; mem_valid in V -> rdy/rdata in V+1.
// Backpressure: owner holds req until its rdy pulse; mem_* are held until mem_valid.
// Optional feature: define BRAM_ARB_STATS_EN to build the saturating grant and
// contention counters. Without it the stat_* ports are tied to zero.
//
// Ports:
//   sys_clock, reset                      clock, async active-high reset
//   inst_*/data_* (req,write,addr,wdata)  requester inputs
//   inst_rdata/data_rdata, inst_rdy/data_rdy  registered completion outputs
//   mem_req/mem_write/mem_addr/mem_wdata  BRAM request (held until mem_valid)
//   mem_rdata/mem_valid                   BRAM completion
//   grant_o                               owner: 00 none, 01 data, 10 inst
//   stat_*                                statistics counters
module bram_port_arbiter #(
    parameter int MEM_ADDR_BITS = 15,
    parameter int DATA_WIDTH    = 128,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     sys_clock,
    input  logic                     reset,
    input  logic                     inst_req,
    input  logic                     inst_write,
    input  logic [MEM_ADDR_BITS-1:0] inst_addr,
    input  logic [DATA_WIDTH-1:0]    inst_wdata,
    output logic [DATA_WIDTH-1:0]    inst_rdata,
    output logic                     inst_rdy,
    input  logic                     data_req,
    input  logic                     data_write,
    input  logic [MEM_ADDR_BITS-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]    data_wdata,
    output logic [DATA_WIDTH-1:0]    data_rdata,
    output logic                     data_rdy,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_valid,
    output logic [1:0]               grant_o,
    output logic [31:0]              stat_inst_grants,
    output logic [31:0]              stat_data_grants,
    output logic [31:0]              stat_contention
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_D  = 2'd1,
        BUSY_I  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t                   state_q, state_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_write_q, mem_write_d;
    logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]    inst_rdata_q, inst_rdata_d;
    logic [DATA_WIDTH-1:0]    data_rdata_q, data_rdata_d;
    logic                     inst_rdy_q, inst_rdy_d;
    logic                     data_rdy_q, data_rdy_d;
    logic [1:0]               grant_q, grant_d;
    logic [3:0]               starve_q, starve_d;

    // Arbitration decision, only meaningful in IDLE. Inst wins a tie once
    // it has watched STARVE_LIMIT data grants go by.
    logic data_go;
    logic grant_data;
    logic grant_inst;
    logic contention;

    assign data_go    = data_req && !(inst_req && (starve_q >= STARVE_LIM));
    assign grant_data = (state_q == IDLE) && data_go;
    assign grant_inst = (state_q == IDLE) && !data_go && inst_req;
    assign contention = (state_q == IDLE) && data_req && inst_req;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_rdy_d   = 1'b0;
        data_rdy_d   = 1'b0;
        grant_d      = grant_q;
        starve_d     = starve_q;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_write_d = data_write;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                    grant_d     = 2'b01;
                    // Count only grants that made a waiting inst fetch wait longer.
                    if (!inst_req) begin
                        starve_d = 4'd0;
                    end else if (starve_q != 4'hF) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (grant_inst) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_write_d = inst_write;
                    mem_addr_d  = inst_addr;
                    mem_wdata_d = inst_wdata;
                    grant_d     = 2'b10;
                    starve_d    = 4'd0;
                end else begin
                    starve_d = 4'd0;
                end
            end
            BUSY_D: begin
                if (mem_valid) begin
                    if (!mem_write_q) begin
                        data_rdata_d = mem_rdata;
                    end
                    data_rdy_d = 1'b1;
                    mem_req_d  = 1'b0;
                    grant_d    = 2'b00;
                    state_d    = RELEASE;
                end
            end
            BUSY_I: begin
                if (mem_valid) begin
                    if (!mem_write_q) begin
                        inst_rdata_d = mem_rdata;
                    end
                    inst_rdy_d = 1'b1;
                    mem_req_d  = 1'b0;
                    grant_d    = 2'b00;
                    state_d    = RELEASE;
                end
            end
            // One dead cycle so the finished owner can drop req before the
            // next arbitration sees it.
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                grant_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_rdy_q   <= 1'b0;
            data_rdy_q   <= 1'b0;
            grant_q      <= 2'b00;
            starve_q     <= 4'd0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_rdy_q   <= inst_rdy_d;
            data_rdy_q   <= data_rdy_d;
            grant_q      <= grant_d;
            starve_q     <= starve_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_rdy   = inst_rdy_q;
    assign data_rdy   = data_rdy_q;
    assign grant_o    = grant_q;

`ifdef BRAM_ARB_STATS_EN
    logic [31:0] stat_inst_q;
    logic [31:0] stat_data_q;
    logic [31:0] stat_cont_q;

    // Saturating counters: they stick at all-ones rather than wrap.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            stat_inst_q <= '0;
            stat_data_q <= '0;
            stat_cont_q <= '0;
        end else begin
            if (grant_inst && (stat_inst_q != 32'hFFFF_FFFF)) begin
                stat_inst_q <= stat_inst_q + 32'd1;
            end
            if (grant_data && (stat_data_q != 32'hFFFF_FFFF)) begin
                stat_data_q <= stat_data_q + 32'd1;
            end
            if (contention && (stat_cont_q != 32'hFFFF_FFFF)) begin
                stat_cont_q <= stat_cont_q + 32'd1;
            end
        end
    end

    assign stat_inst_grants = stat_inst_q;
    assign stat_data_grants = stat_data_q;
    assign stat_contention  = stat_cont_q;
`else
    logic unused_stats;
    assign unused_stats     = contention;
    assign stat_inst_grants = 32'd0;
    assign stat_data_grants = 32'd0;
    assign stat_contention  = 32'd0;
`endif

endmodule
